// File: rtl/datapath_gray.sv
// datapath_gray: packs R,G,B byte triplets into one luma byte, buffered by an output FIFO
`timescale 1ns/1ps
module datapath_gray #(
  parameter int FIFO_DEPTH = 4,
  parameter int COEF_R = 77,
  parameter int COEF_G = 150,
  parameter int COEF_B = 29
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  input  logic       sof_in,
  output logic       busy_out,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       sof_out,
  input  logic       busy_in
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [1:0] cnt, slot;
  logic [7:0] r_q, g_q, pipe_data, gray;
  logic pix_sof, pipe_valid, pipe_sof, accept, pop;
  logic [8:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [15:0] sum;
  always_comb begin
    busy_out = !i_rst || (count + (AW+1)'(pipe_valid) >= (AW+1)'(FIFO_DEPTH));
    accept = valid_in && !busy_out;
    slot = sof_in ? 2'd0 : cnt;
    sum = 16'(r_q) * 16'(COEF_R) + 16'(g_q) * 16'(COEF_G) + 16'(data_in) * 16'(COEF_B);
    gray = 8'(sum >> 8);
    valid_out = count != '0;
    data_out = valid_out ? mem[rd_ptr][7:0] : 8'd0;
    sof_out = valid_out ? mem[rd_ptr][8] : 1'b0;
    pop = valid_out && !busy_in;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cnt <= '0;
      r_q <= '0;
      g_q <= '0;
      pix_sof <= 1'b0;
      pipe_valid <= 1'b0;
      pipe_sof <= 1'b0;
      pipe_data <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      pipe_valid <= accept && slot == 2'd2;
      if (accept) begin
        cnt <= slot == 2'd2 ? 2'd0 : slot + 2'd1;
        if (slot == 2'd0) begin
          r_q <= data_in;
          pix_sof <= sof_in;
        end
        if (slot == 2'd1) g_q <= data_in;
        if (slot == 2'd2) begin
          pipe_data <= gray;
          pipe_sof <= pix_sof;
        end
      end
      if (pipe_valid) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(pipe_valid) - (AW+1)'(pop);
    end
  end
  // Storage carries no reset; occupancy is tracked solely by count.
  always_ff @(posedge i_clk) begin
    if (pipe_valid) mem[wr_ptr] <= {pipe_sof, pipe_data};
  end
endmodule

// File: tb/tb_datapath_gray.sv
// tb_datapath_gray: directed table and sequence checks for datapath_gray
`timescale 1ns/1ps
module tb_datapath_gray;
  logic i_clk = 1'b0, i_rst = 1'b0, valid_in = 1'b0, sof_in = 1'b0, busy_in = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic busy_out, valid_out, sof_out;
  logic [7:0] data_out;
  int n_chk = 0, n_fail = 0;
  logic mon_en = 1'b0;
  logic [8:0] got[$], exp_q[$];
  typedef struct { logic s; logic [7:0] r, g, b, y; } vec_t;
  vec_t tbl[12];
  logic [7:0] vals[4];

  always #5 i_clk = ~i_clk;

  datapath_gray dut (
    .i_clk(i_clk), .i_rst(i_rst), .data_in(data_in), .valid_in(valid_in),
    .sof_in(sof_in), .busy_out(busy_out), .data_out(data_out),
    .valid_out(valid_out), .sof_out(sof_out), .busy_in(busy_in)
  );

  always @(negedge i_clk)
    if (mon_en && i_rst && valid_out && !busy_in) got.push_back({sof_out, data_out});

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    int w = 0;
    valid_in = 1'b1;
    data_in = d;
    sof_in = s;
    while (busy_out && w < 200) begin
      tick();
      w++;
    end
    if (busy_out) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: busy_out got 1, expected 0");
    end
    tick();
    valid_in = 1'b0;
    sof_in = 1'b0;
    data_in = 8'd0;
  endtask

  task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic s);
    send(r, s);
    send(g, 1'b0);
    send(b, 1'b0);
  endtask

  task automatic check_got(input string name);
    chk({name, "_count"}, 9'(got.size()), 9'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(name, got[i], exp_q[i]);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[2]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[3]  = '{1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[4]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[5]  = '{1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[6]  = '{1'b0, 8'h00, 8'h00, 8'h00, 8'h00};
    tbl[7]  = '{1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[8]  = '{1'b0, 8'h1F, 8'h3F, 8'h7F, 8'h3C};
    tbl[9]  = '{1'b0, 8'hFF, 8'h00, 8'h00, 8'h4C};
    tbl[10] = '{1'b0, 8'h00, 8'hFF, 8'h00, 8'h95};
    tbl[11] = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'h1C};
    vals = '{8'h50, 8'h60, 8'h70, 8'h80};

    tick(2);
    chk("rst_valid_out", 9'(valid_out), 9'd0);
    chk("rst_data_out", 9'(data_out), 9'd0);
    chk("rst_sof_out", 9'(sof_out), 9'd0);
    chk("rst_busy_out", 9'(busy_out), 9'd1);
    i_rst = 1'b1;
    tick();
    chk("busy_after_release", 9'(busy_out), 9'd0);

    for (int i = 0; i < 12; i++) begin
      pix(tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].s);
      chk("lat_not_yet", 9'(valid_out), 9'd0);
      tick();
      chk("lat_valid", 9'(valid_out), 9'd1);
      chk("gray_data", 9'(data_out), 9'(tbl[i].y));
      chk("gray_sof", 9'(sof_out), 9'(tbl[i].s));
      tick();
      chk("popped_empty", 9'(valid_out), 9'd0);
    end

    got.delete();
    exp_q.delete();
    mon_en = 1'b1;
    busy_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pix(8'(16 * (i + 1)), 8'(16 * (i + 1)), 8'(16 * (i + 1)), i == 0);
      exp_q.push_back({i == 0, 8'(16 * (i + 1))});
    end
    chk("stall_busy", 9'(busy_out), 9'd1);
    chk("stall_head", {sof_out, data_out}, 9'h110);
    tick(3);
    chk("stall_busy_held", 9'(busy_out), 9'd1);
    chk("stall_head_held", {valid_out, data_out}, 9'h110);
    busy_in = 1'b0;
    pix(8'h50, 8'h50, 8'h50, 1'b0);
    exp_q.push_back(9'h050);
    pix(8'h60, 8'h60, 8'h60, 1'b0);
    exp_q.push_back(9'h060);
    tick(20);
    check_got("stall_drain");

    got.delete();
    exp_q.delete();
    send(8'hAA, 1'b1);
    send(8'hBB, 1'b0);
    pix(8'h20, 8'h20, 8'h20, 1'b1);
    exp_q.push_back(9'h120);
    sof_in = 1'b1;
    tick();
    sof_in = 1'b0;
    pix(8'h30, 8'h30, 8'h30, 1'b0);
    exp_q.push_back(9'h030);
    tick(5);
    check_got("sof_restart");
    mon_en = 1'b0;

    busy_in = 1'b1;
    for (int i = 0; i < 4; i++) pix(vals[i], vals[i], vals[i], 1'b0);
    tick();
    chk("fill_busy", {valid_out, busy_out}, 9'd3);
    for (int j = 0; j < 8; j++) begin
      tick();
      chk("toggle_hold", {valid_out, data_out}, 9'h150);
    end
    busy_in = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk("toggle_valid", 9'(valid_out), 9'(j < 4));
      if (j < 4) chk("toggle_data", 9'(data_out), 9'(vals[j]));
    end
    busy_in = 1'b1;
    tick(8);
    busy_in = 1'b0;
    tick(8);
    chk("toggle_empty", {valid_out, busy_out}, 9'd0);

    busy_in = 1'b1;
    pix(8'h11, 8'h11, 8'h11, 1'b1);
    pix(8'h22, 8'h22, 8'h22, 1'b0);
    send(8'h99, 1'b0);
    tick();
    chk("prerst_valid", 9'(valid_out), 9'd1);
    i_rst = 1'b0;
    tick();
    chk("midrst_valid", 9'(valid_out), 9'd0);
    chk("midrst_busy", 9'(busy_out), 9'd1);
    chk("midrst_data", {sof_out, data_out}, 9'd0);
    i_rst = 1'b1;
    busy_in = 1'b0;
    tick();
    chk("postrst_busy", 9'(busy_out), 9'd0);
    pix(8'h40, 8'h40, 8'h40, 1'b0);
    chk("postrst_lat", 9'(valid_out), 9'd0);
    tick();
    chk("postrst_pixel", {sof_out, data_out}, 9'h040);
    chk("postrst_valid", 9'(valid_out), 9'd1);
    tick();
    chk("postrst_empty", 9'(valid_out), 9'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
